// File: rtl/multi_led_pwm_fader_if.sv
// Control/status bundle between board logic and the multi-channel LED PWM fader.
// The master drives run control and levels; the slave returns PWM pins and status.
interface multi_led_pwm_fader_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_RES  = 8
);
  logic                         en;
  logic [1:0]                   mode;
  logic                         load;
  logic [CHANNELS*PWM_RES-1:0]  level_in;
  logic [CHANNELS-1:0]          pwm_out;
  logic                         cycle_done;
  logic                         busy;

  modport master (
    output en, mode, load, level_in,
    input  pwm_out, cycle_done, busy
  );

  modport slave (
    input  en, mode, load, level_in,
    output pwm_out, cycle_done, busy
  );
endinterface

// File: rtl/multi_led_pwm_fader.sv
// Multi-channel LED PWM generator with per-channel brightness and fade engines
// (static, fade-down, fade-up, breathe), stepped once per PWM period.
module multi_led_pwm_fader #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_RES  = 8,
  parameter int unsigned PRESCALE = 2048,
  parameter int unsigned STEP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_led_pwm_fader_if.slave  bus
);

  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned EXT_W = PWM_RES + 1;
  localparam logic [PWM_RES-1:0] MAX    = {PWM_RES{1'b1}};
  localparam logic [EXT_W-1:0]   MAX_X  = {1'b0, MAX};
  localparam logic [EXT_W-1:0]   STEP_X = EXT_W'(STEP);
  localparam logic [EXT_W-1:0]   UP_LIM = MAX_X - STEP_X;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UP      = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PS_W-1:0]                    presc_q, presc_d;
  logic [PWM_RES-1:0]                 pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0][PWM_RES-1:0]   bright_q, bright_d;
  dir_e                               dir_q [CHANNELS];
  dir_e                               dir_d [CHANNELS];
  logic [CHANNELS-1:0]                pwm_out_q, pwm_out_d;
  logic                               cycle_done_q, cycle_done_d;
  logic                               tick, pe, busy_c;
  mode_e                              mode;

  // Saturating steps evaluated one bit wider so no intermediate can wrap.
  function automatic logic [PWM_RES-1:0] inc_sat(input logic [PWM_RES-1:0] b);
    logic [EXT_W-1:0] bx;
    bx = {1'b0, b};
    return (bx >= UP_LIM) ? MAX : PWM_RES'(bx + STEP_X);
  endfunction

  function automatic logic [PWM_RES-1:0] dec_sat(input logic [PWM_RES-1:0] b);
    logic [EXT_W-1:0] bx;
    bx = {1'b0, b};
    return (bx <= STEP_X) ? '0 : PWM_RES'(bx - STEP_X);
  endfunction

  assign mode = mode_e'(bus.mode);
  assign tick = bus.en && (presc_q == PS_W'(PRESCALE - 1));
  assign pe   = tick && (pwm_cnt_q == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      bright_q     <= '0;
      pwm_out_q    <= '0;
      cycle_done_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) dir_q[i] <= DIR_UP;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      bright_q     <= bright_d;
      pwm_out_q    <= pwm_out_d;
      cycle_done_q <= cycle_done_d;
      dir_q        <= dir_d;
    end
  end

  always_comb begin
    presc_d      = presc_q;
    pwm_cnt_d    = pwm_cnt_q;
    bright_d     = bright_q;
    dir_d        = dir_q;
    pwm_out_d    = '0;
    cycle_done_d = pe;

    if (bus.en) presc_d = tick ? '0 : presc_q + PS_W'(1);
    if (tick)   pwm_cnt_d = pwm_cnt_q + PWM_RES'(1);

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_out_d[i] = bus.en && (pwm_cnt_q < bright_q[i]);

      // A load overrides any fade step landing on the same clock.
      if (bus.load) begin
        bright_d[i] = bus.level_in[i*PWM_RES +: PWM_RES];
        dir_d[i]    = DIR_UP;
      end else if (pe) begin
        case (mode)
          MODE_DOWN: bright_d[i] = dec_sat(bright_q[i]);
          MODE_UP:   bright_d[i] = inc_sat(bright_q[i]);
          MODE_BREATHE: begin
            if (dir_q[i] == DIR_UP) begin
              bright_d[i] = inc_sat(bright_q[i]);
              if ({1'b0, bright_q[i]} >= UP_LIM) dir_d[i] = DIR_DOWN;
            end else begin
              bright_d[i] = dec_sat(bright_q[i]);
              if ({1'b0, bright_q[i]} <= STEP_X) dir_d[i] = DIR_UP;
            end
          end
          default: bright_d[i] = bright_q[i];
        endcase
      end
    end
  end

  // Fade-in-progress flag; gated by rst so it drops with the other outputs.
  always_comb begin
    busy_c = 1'b0;
    case (mode)
      MODE_DOWN:    busy_c = bus.en && (|bright_q);
      MODE_UP:      busy_c = bus.en && !(&bright_q);
      MODE_BREATHE: busy_c = bus.en;
      default:      busy_c = 1'b0;
    endcase
    if (rst) busy_c = 1'b0;
  end

  assign bus.pwm_out    = pwm_out_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.busy       = busy_c;

endmodule
